// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution stage: opcode and state encodings.
// The control FSM stage imports this package too, so the opcode encoding is
// defined in a single place.
package alu_exec_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Command/result bundle between the ALU control FSM (master) and the
// execution stage (slave).
//   start, abort   launch / cancel strobes
//   op, a, b       opcode and operands, sampled on an accepted start
//   result         registered result of the last completed op
//   overflow       overflow flag of the last completed op
//   busy           op in flight, start ignored
//   done           one-cycle pulse when result/overflow are updated
interface alu_exec_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, op, a, b,
        input  result, overflow, busy, done
    );

    modport slave (
        input  start, abort, op, a, b,
        output result, overflow, busy, done
    );
endinterface

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
//   clk, rst   clock, async active-high reset
//   load       capture a/b, clear accumulator, arm WIDTH steps
//   step       add one partial product and advance
//   a, b       operands (used on load only)
//   product    accumulator value including the current step's partial
//              product, so the owner can register the final value on the
//              same edge as the last step
//   last       the current step is the final one
module alu_exec_unit_mul_iter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [SHW-1:0]     count_q;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product  = acc_next;
    assign last     = (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= SHW'(WIDTH - 1);
        end else if (step) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage. Latches opcode and operands on an accepted start,
// computes single-cycle ops in EXEC and multiplies iteratively in MUL, then
// registers result/overflow and pulses done.
//   clk, rst   clock, async active-high reset
//   bus        alu_exec_unit_if slave: start/abort/op/a/b in,
//              result/overflow/busy/done out
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; result/overflow hold last completed op
// EXEC    | single-cycle op; result written and done pulsed on exit
// MUL     | one shift-add step per cycle; written on the last step
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);

    state_e             state_q, state_d;
    opcode_e            op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   result_q;
    logic               overflow_q;
    logic               done_q;

    logic               accept, exec_wr, mul_step, mul_wr;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_last;

    logic [WIDTH-1:0]   exec_result;
    logic               exec_ovf;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [2*WIDTH-1:0] shl_ext;
    logic [SHW-1:0]     sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // abort takes priority everywhere: in IDLE it suppresses the launch,
    // in EXEC/MUL it drops the op without touching result/overflow.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        exec_wr  = 1'b0;
        mul_step = 1'b0;
        mul_wr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    accept  = 1'b1;
                    state_d = (bus.op == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (!bus.abort) exec_wr = 1'b1;
            end
            ST_MUL: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        mul_wr  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OP_ADD;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= opcode_e'(bus.op);
            a_q  <= bus.a;
            b_q  <= bus.b;
        end
    end

    alu_exec_unit_mul_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .step    (mul_step),
        .a       (bus.a),
        .b       (bus.b),
        .product (mul_product),
        .last    (mul_last)
    );

    // Signed overflow is carry into the sign bit xor carry out of it.
    // Subtraction is a + ~b + 1 so the same rule applies.
    assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_ext = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    assign sh       = b_q[SHW-1:0];
    assign shl_ext  = {{WIDTH{1'b0}}, a_q} << sh;

    always_comb begin
        exec_result = '0;
        exec_ovf    = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_result = sum_ext[WIDTH-1:0];
                exec_ovf    = sum_ext[WIDTH]
                            ^ (sum_ext[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_result = diff_ext[WIDTH-1:0];
                exec_ovf    = diff_ext[WIDTH]
                            ^ (diff_ext[WIDTH-1] ^ a_q[WIDTH-1] ^ ~b_q[WIDTH-1]);
            end
            OP_AND: exec_result = a_q & b_q;
            OP_OR:  exec_result = a_q | b_q;
            OP_XOR: exec_result = a_q ^ b_q;
            OP_SHL: begin
                exec_result = shl_ext[WIDTH-1:0];
                exec_ovf    = |shl_ext[2*WIDTH-1:WIDTH];
            end
            OP_SHR: exec_result = a_q >> sh;
            default: begin
                exec_result = '0;
                exec_ovf    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= exec_wr | mul_wr;
            if (exec_wr) begin
                result_q   <= exec_result;
                overflow_q <= exec_ovf;
            end else if (mul_wr) begin
                result_q   <= mul_product[WIDTH-1:0];
                overflow_q <= |mul_product[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random ops checked
// against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic clk = 1'b0;
    logic rst;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus();

    alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_res  = 0;
    int exp_ovf  = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model from plain integer arithmetic.
    function automatic void ref_op(input int o, input int x, input int y,
                                   output int r, output int v);
        int sx, sy, s, sh, full;
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        sh = y % WIDTH;
        r = 0;
        v = 0;
        case (o)
            0: begin s = sx + sy; r = (x + y) % 256;       v = int'(s > 127 || s < -128); end
            1: begin s = sx - sy; r = (x - y + 256) % 256; v = int'(s > 127 || s < -128); end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin full = x << sh; r = full % 256; v = int'(full > 255); end
            6: r = x >> sh;
            default: begin full = x * y; r = full % 256; v = int'(full > 255); end
        endcase
    endfunction

    task automatic do_op(input int o, input int x, input int y, input bit poke);
        int r, v, lat;
        ref_op(o, x, y, r, v);
        @(negedge clk);
        bus.op = 3'(o); bus.a = 8'(x); bus.b = 8'(y); bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        lat = 0;
        while (!bus.done && lat < 40) begin
            check_val("busy_in_flight", int'(bus.busy), 1);
            if (poke) begin
                bus.start = 1'b1;
                bus.op    = 3'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check_val("latency", lat, (o == 7) ? WIDTH : 1);
        if (lat < 40) begin
            exp_res = r;
            exp_ovf = v;
        end
        check_val("result", int'(bus.result), exp_res);
        check_val("overflow", int'(bus.overflow), exp_ovf);
        check_val("busy_after_done", int'(bus.busy), 0);
        @(negedge clk);
        check_val("done_one_cycle", int'(bus.done), 0);
    endtask

    task automatic expect_no_done(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check_val(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        check_val("rst_result", int'(bus.result), 0);
        check_val("rst_overflow", int'(bus.overflow), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_done", int'(bus.done), 0);
        rst = 1'b0;

        // Directed cases
        do_op(0, 8'h7F, 8'h01, 0);
        do_op(0, 3, 4, 0);
        do_op(1, 8'h80, 8'h01, 0);
        do_op(5, 8'h81, 1, 0);
        do_op(7, 15, 17, 1);
        do_op(7, 16, 16, 0);
        do_op(6, 8'hF0, 8'h0C, 0);
        do_op(5, 8'h01, 8'h0F, 0);

        // Random ops
        repeat (40) do_op(int'($urandom % 8), int'($urandom % 256), int'($urandom % 256), 0);

        // Abort mid-MUL on the third cycle
        do_op(0, 8'h7F, 8'h01, 0);
        @(negedge clk);
        bus.op = 3'd7; bus.a = 8'd15; bus.b = 8'd17; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_mul_busy", int'(bus.busy), 0);
        check_val("abort_mul_done", int'(bus.done), 0);
        check_val("abort_mul_result", int'(bus.result), exp_res);
        check_val("abort_mul_ovf", int'(bus.overflow), exp_ovf);
        expect_no_done(WIDTH + 2, "abort_mul_no_done");

        // Abort in EXEC
        @(negedge clk);
        bus.op = 3'd4; bus.a = 8'h0F; bus.b = 8'hAA; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_exec_busy", int'(bus.busy), 0);
        check_val("abort_exec_done", int'(bus.done), 0);
        check_val("abort_exec_result", int'(bus.result), exp_res);

        // start and abort together in IDLE
        @(negedge clk);
        bus.op = 3'd0; bus.a = 8'd1; bus.b = 8'd1; bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check_val("start_abort_busy", int'(bus.busy), 0);
        expect_no_done(3, "start_abort_no_done");
        check_val("start_abort_result", int'(bus.result), exp_res);

        // Back-to-back XOR then OR with start held
        @(negedge clk);
        bus.op = 3'd4; bus.a = 8'h3C; bus.b = 8'h0F; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.op = 3'd3; bus.a = 8'h50; bus.b = 8'h05;
        check_val("b2b_no_done_early", int'(bus.done), 0);
        @(negedge clk);
        check_val("b2b_done1", int'(bus.done), 1);
        check_val("b2b_xor", int'(bus.result), 8'h33);
        @(negedge clk);
        bus.start = 1'b0;
        check_val("b2b_gap", int'(bus.done), 0);
        check_val("b2b_busy2", int'(bus.busy), 1);
        @(negedge clk);
        check_val("b2b_done2", int'(bus.done), 1);
        check_val("b2b_or", int'(bus.result), 8'h55);
        exp_res = 8'h55; exp_ovf = 0;

        // Reset asserted mid-MUL, off the clock edge
        do_op(0, 8'h7F, 8'h01, 0);
        @(negedge clk);
        bus.op = 3'd7; bus.a = 8'd15; bus.b = 8'd17; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("midrst_result", int'(bus.result), 0);
        check_val("midrst_overflow", int'(bus.overflow), 0);
        check_val("midrst_busy", int'(bus.busy), 0);
        check_val("midrst_done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_res = 0; exp_ovf = 0;
        expect_no_done(WIDTH + 2, "midrst_no_done");
        do_op(0, 3, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
